// File: rtl/gray_ctrl_pkg.sv
// rtl/gray_ctrl_pkg.sv - shared state encoding and gray-code constants for the gray counter sequencer
package gray_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COUNT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_HOLD
    } ctrl_state_e;

    // Gray code of the all-ones binary count: only the MSB is set.
    function automatic logic [63:0] gray_of_all_ones(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/gray_count_ctrl_if.sv
// rtl/gray_count_ctrl_if.sv - control, counter-tree and result signals of the gray counter sequencer
interface gray_count_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int WIN_W = 16
);
    logic             start;
    logic             abort;
    logic [WIN_W-1:0] cfg_win_len;
    logic             cfg_continuous;
    logic [WIDTH-1:0] gray_in;
    logic             cnt_clr;
    logic             cnt_en;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, abort, cfg_win_len, cfg_continuous, gray_in, out_ready,
        input  cnt_clr, cnt_en, out_data, out_ovf, out_valid, busy
    );

    modport slave (
        input  start, abort, cfg_win_len, cfg_continuous, gray_in, out_ready,
        output cnt_clr, cnt_en, out_data, out_ovf, out_valid, busy
    );
endinterface

// File: rtl/gray_to_bin.sv
// rtl/gray_to_bin.sv - combinational gray-to-binary converter
module gray_to_bin #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_count_ctrl.sv
// rtl/gray_count_ctrl.sv - sequences an external gray counter tree over a fixed window and returns the binary count
module gray_count_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WIN_W = 16
) (
    input  logic              clk_master,
    input  logic              rst,
    gray_count_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] OVF_GRAY = WIDTH'(gray_of_all_ones(WIDTH));

    ctrl_state_e      state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic             cont_q, cont_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] bin_w;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .gray_i (bus.gray_in),
        .bin_o  (bin_w)
    );

    always_ff @(posedge clk_master or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cont_q      <= 1'b0;
            win_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cont_q      <= cont_d;
            win_cnt_q   <= win_cnt_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cont_d      = cont_q;
        win_cnt_d   = win_cnt_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (bus.abort) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_CLEAR;
                        len_d   = (bus.cfg_win_len == '0) ? WIN_W'(1) : bus.cfg_win_len;
                        cont_d  = bus.cfg_continuous;
                    end
                end
                ST_CLEAR: begin
                    win_cnt_d = '0;
                    ovf_d     = 1'b0;
                    state_d   = ST_COUNT;
                end
                ST_COUNT: begin
                    // gray_in shows the pre-increment value, so the all-ones code here means the next step wraps.
                    if (bus.gray_in == OVF_GRAY) begin
                        ovf_d = 1'b1;
                    end
                    if (win_cnt_q == len_q - WIN_W'(1)) begin
                        state_d = ST_SETTLE;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                    end
                end
                ST_SETTLE: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    out_data_d  = bin_w;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = cont_q ? ST_CLEAR : ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_clr   = (state_q == ST_CLEAR);
    assign bus.cnt_en    = (state_q == ST_COUNT);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule
